// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: stall / flush / halt sequencer for a 5-stage MIPS-style pipeline.
// Detects load-use and branch-operand hazards, freezes the pipe on a pending
// data-RAM access, kills the fetched instruction behind taken branches, and
// drains the pipe after a STOP opcode before halting.
// Optional feature: define STALL_CNT_EN to build the saturating StallCount
// counter. Without it, StallCount is tied to zero and no counter flops exist.
//
// Memory handshake: MEM_Req is the request (valid) from the MEM stage and
// MemReady is the completion (ready) from the data RAM. The access completes
// in a cycle where both are high. A cycle with MEM_Req high and MemReady low
// is a freeze cycle: every stage register holds. The request is never dropped
// while it is waiting for MemReady.
module pipe_seq_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_Taken,
    input  logic             ID_Stop,
    input  logic             EX_RegWriteEN,
    input  logic             EX_Load,
    input  logic [4:0]       EX_WReg,
    input  logic             MEM_RegWriteEN,
    input  logic             MEM_Load,
    input  logic [4:0]       MEM_WReg,
    input  logic             MEM_Req,
    input  logic             MemReady,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IDEX_EN,
    output logic             EXMEM_EN,
    output logic             MEMWB_EN,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount,
    output logic [1:0]       DbgState
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_drain;
    logic [2:0] w_drain_next;
    logic       r_halted;

    logic w_ex_match;
    logic w_mem_match;
    logic w_load_use;
    logic w_branch_haz;
    logic w_hazard;
    logic w_freeze;
    logic w_stall_evt;

    // Register r matches a pending write to w; $0 never creates a dependence.
    function automatic logic f_match(input logic [4:0] r, input logic [4:0] w);
        return (w != 5'd0) && (w == r);
    endfunction

    // Operand dependence of the ID instruction on the EX / MEM destinations.
    assign w_ex_match  = f_match(ID_Rs, EX_WReg)  || (ID_UsesRt && f_match(ID_Rt, EX_WReg));
    assign w_mem_match = f_match(ID_Rs, MEM_WReg) || (ID_UsesRt && f_match(ID_Rt, MEM_WReg));

    // A load in EX cannot forward in time for anyone; branches resolve in ID
    // and so also wait for any EX result and for a load still in MEM.
    assign w_load_use   = EX_Load && EX_RegWriteEN && w_ex_match;
    assign w_branch_haz = ID_Branch &&
                          ((EX_RegWriteEN && w_ex_match) ||
                           (MEM_Load && MEM_RegWriteEN && w_mem_match));
    assign w_hazard     = (r_state == ST_RUN) && (w_load_use || w_branch_haz);

    // A waiting data-RAM access freezes everything except a halted core.
    assign w_freeze = MEM_Req && !MemReady && (r_state != ST_HALT);

    // Next-state, drain count and stage control by priority:
    // reset, halt, freeze, hazard, stop, taken branch.
    always_comb begin
        w_state_next = r_state;
        w_drain_next = r_drain;
        w_stall_evt  = 1'b0;
        PC_EN        = 1'b0;
        IFID_EN      = 1'b0;
        IDEX_EN      = 1'b0;
        EXMEM_EN     = 1'b0;
        MEMWB_EN     = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        if (!RST) begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        w_stall_evt = 1'b1;
                    end else if (w_hazard) begin
                        w_stall_evt = 1'b1;
                        IDEX_EN     = 1'b1;
                        EXMEM_EN    = 1'b1;
                        MEMWB_EN    = 1'b1;
                        IDEX_Flush  = 1'b1;
                    end else if (ID_Stop) begin
                        IFID_EN      = 1'b1;
                        IDEX_EN      = 1'b1;
                        EXMEM_EN     = 1'b1;
                        MEMWB_EN     = 1'b1;
                        IFID_Flush   = 1'b1;
                        w_state_next = ST_DRAIN;
                        w_drain_next = 3'(DRAIN_CYCLES);
                    end else begin
                        PC_EN      = 1'b1;
                        IFID_EN    = 1'b1;
                        IDEX_EN    = 1'b1;
                        EXMEM_EN   = 1'b1;
                        MEMWB_EN   = 1'b1;
                        IFID_Flush = ID_Taken;
                    end
                end
                ST_DRAIN: begin
                    if (w_freeze) begin
                        w_stall_evt = 1'b1;
                    end else begin
                        IFID_EN    = 1'b1;
                        IDEX_EN    = 1'b1;
                        EXMEM_EN   = 1'b1;
                        MEMWB_EN   = 1'b1;
                        IFID_Flush = 1'b1;
                        // Halt follows the advancing cycle that empties the count.
                        if (r_drain <= 3'd1) begin
                            w_drain_next = 3'd0;
                            w_state_next = ST_HALT;
                        end else begin
                            w_drain_next = r_drain - 3'd1;
                        end
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_drain_next = 3'd0;
                end
            endcase
        end
    end

    // State, drain counter and halted flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_RUN;
            r_drain  <= 3'd0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_drain  <= w_drain_next;
            r_halted <= (w_state_next == ST_HALT);
        end
    end

    assign Halted   = r_halted;
    assign DbgState = r_state;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count hazard and freeze cycles, sticking at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign StallCount = r_stall_cnt;
`else
    logic w_unused_stall_evt;

    assign w_unused_stall_evt = w_stall_evt;
    assign StallCount         = '0;
`endif

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: number of advancing cycles after STOP before halt (range 1..7).
REQ-002 SHALL have parameter CNT_W, default 16: StallCount width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports ID_Rs and ID_Rt, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have port ID_UsesRt, input, 1: high when ID reads Rt (R-type, BEQ, BNE, SW).
REQ-007 SHALL have port ID_Branch, input, 1: Beq, Bne or Jr decoded in ID (compared or read in ID).
REQ-008 SHALL have port ID_Taken, input, 1: branch/jump in ID redirects the PC (taken BEQ/BNE, J, JAL, JR).
REQ-009 SHALL have port ID_Stop, input, 1: opcode 6'd63 in ID.
REQ-010 SHALL have ports EX_RegWriteEN and EX_Load, input, 1 each, plus EX_WReg, input, 5: EX-stage write enable, Mem2RegSEL==1, and destination.
REQ-011 SHALL have ports MEM_RegWriteEN and MEM_Load, input, 1 each, plus MEM_WReg, input, 5: MEM-stage equivalents.
REQ-012 SHALL have ports MEM_Req, input, 1 (LW/SW in MEM), and MemReady, input, 1 (data RAM completes this cycle).
REQ-013 SHALL have ports PC_EN, IFID_EN, IDEX_EN, EXMEM_EN and MEMWB_EN, output, 1 each: stage-register load enables.
REQ-014 SHALL have ports IFID_Flush and IDEX_Flush, output, 1 each: load a bubble (all controls 0) into the register.
REQ-015 SHALL have ports Halted, output, 1, and StallCount, output, CNT_W: registered status.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN, HALT; enables and flushes combinational from state and inputs.
REQ-017 SHALL define Match(r,w) as (w != 0 && w == r), checked on Rs always and on Rt only if ID_UsesRt.
REQ-018 SHALL raise load-use hazard when EX_Load && EX_RegWriteEN && Match in RUN.
REQ-019 SHALL raise branch hazard when ID_Branch && ((EX_RegWriteEN && Match EX_WReg) || (MEM_Load && MEM_RegWriteEN && Match MEM_WReg)); a load feeding a branch thus gives 2 bubbles.
REQ-020 SHALL, on a hazard: PC_EN=0, IFID_EN=0, IDEX_Flush=1, other enables 1; no IFID_Flush and no STOP acceptance that cycle.
REQ-021 SHALL, on freeze (MEM_Req && !MemReady, any state except HALT): all five enables 0 and both flushes 0; freeze overrides hazard, taken-branch and STOP.
REQ-022 SHALL, on ID_Taken with no hazard and no freeze: IFID_Flush=1 with all enables 1 (one fetched instruction killed).
REQ-023 SHALL, on ID_Stop in RUN with no hazard and no freeze: IFID_Flush=1, PC_EN=0, go to DRAIN and load the drain counter with DRAIN_CYCLES.
REQ-024 SHALL, in DRAIN: PC_EN=0, IFID_Flush=1, other enables 1; decrement the counter only on non-freeze cycles; go to HALT in the cycle after the counter reaches 0.
REQ-025 SHALL, in HALT: all enables 0, flushes 0, Halted=1; leave HALT only via RST; ignore MEM_Req and MemReady.
REQ-026 SHALL give priority, highest first: RST, HALT, freeze, hazard, STOP, taken-branch.
REQ-027 SHALL increment StallCount once per hazard or freeze cycle and saturate at all-ones (no wrap).

Reset
REQ-028 SHALL, while RST is high: state RUN, drain counter 0, Halted 0, StallCount 0, all enables 0, flushes 0.
REQ-029 SHALL clear all state immediately on RST mid-DRAIN or mid-freeze; first cycle after release has all enables 1 if no hazard.

Configuration
REQ-030 SHALL, with STALL_CNT_EN defined, implement StallCount per REQ-027; without it, tie StallCount to 0 and instantiate no counter flops.

Verification
REQ-031 SHALL test: LW $2 in EX, ID ADD $3,$2,$4 -> 1 cycle PC_EN=0, IFID_EN=0, IDEX_Flush=1; then all enables 1.
REQ-032 SHALL test: LW $5 in EX, ID BEQ $5,$0 -> 2 consecutive hazard cycles; with STALL_CNT_EN, StallCount goes 0 to 2.
REQ-033 SHALL test: ID J with no hazard -> IFID_Flush=1 exactly 1 cycle, PC_EN=1.
REQ-034 SHALL test: MEM_Req=1, MemReady=0 for 3 cycles while an ID hazard is present -> all enables 0 for 3 cycles, no IDEX_Flush; then hazard handling resumes.
REQ-035 SHALL test: ID_Stop, DRAIN_CYCLES=3, one freeze cycle during drain -> Halted=1 5 cycles after STOP is accepted; enables stay 0 thereafter.
REQ-036 SHALL test: RST pulsed in DRAIN -> Halted=0, StallCount=0, state RUN after release.
